// File: rtl/inv_mix_columns.sv
// inv_mix_columns: byte-serial AES InvMixColumns with per-column bypass and 4-cycle latency
// Ports:
//    clock, reset_n      rising-edge clock, asynchronous active-low reset
//    in_valid, in_byte   accepted state byte, rows 0..3 of each column in order
//    bypass              sampled with row 0; 1 passes the column through unchanged
//    out_valid, out_byte result byte stream, rows 0..3 of each column in order
//    out_last            marks the 16th output byte of each block
module inv_mix_columns (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       in_valid,
   input  logic [7:0] in_byte,
   input  logic       bypass,
   output logic       out_valid,
   output logic [7:0] out_byte,
   output logic       out_last
);
   logic [1:0]  row, col, drain;
   logic [7:0]  a0, a1, a2;
   logic        byp, tag, load;
   logic [23:0] sh;
   logic [7:0]  r0, r1, r2, r3;
   logic [31:0] res;

   function automatic logic [7:0] xt(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction
   function automatic logic [7:0] m9(input logic [7:0] x);
      return xt(xt(xt(x))) ^ x;
   endfunction
   function automatic logic [7:0] mb(input logic [7:0] x);
      return xt(xt(xt(x))) ^ xt(x) ^ x;
   endfunction
   function automatic logic [7:0] md(input logic [7:0] x);
      return xt(xt(xt(x))) ^ xt(xt(x)) ^ x;
   endfunction
   function automatic logic [7:0] me(input logic [7:0] x);
      return xt(xt(xt(x))) ^ xt(xt(x)) ^ xt(x);
   endfunction

   // row 3 is never stored: the live in_byte completes the column on the load edge
   always_comb begin
      load = in_valid && row == 2'd3;
      r0   = me(a0) ^ mb(a1) ^ md(a2) ^ m9(in_byte);
      r1   = me(a1) ^ mb(a2) ^ md(in_byte) ^ m9(a0);
      r2   = me(a2) ^ mb(in_byte) ^ md(a0) ^ m9(a1);
      r3   = me(in_byte) ^ mb(a0) ^ md(a1) ^ m9(a2);
      res  = byp ? {a0, a1, a2, in_byte} : {r0, r1, r2, r3};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         row       <= 2'd0;
         col       <= 2'd0;
         drain     <= 2'd0;
         a0        <= 8'h00;
         a1        <= 8'h00;
         a2        <= 8'h00;
         byp       <= 1'b0;
         tag       <= 1'b0;
         sh        <= 24'h0;
         out_valid <= 1'b0;
         out_byte  <= 8'h00;
         out_last  <= 1'b0;
      end else begin
         if (in_valid) begin
            row <= row + 2'd1;
            if (row == 2'd3) col <= col + 2'd1;
            if (row == 2'd0) begin
               a0  <= in_byte;
               byp <= bypass;
            end
            if (row == 2'd1) a1 <= in_byte;
            if (row == 2'd2) a2 <= in_byte;
         end
         // a load can only land on the cycle after r3, so it simply overrides the drain
         if (load) begin
            out_valid <= 1'b1;
            out_byte  <= res[31:24];
            sh        <= res[23:0];
            drain     <= 2'd0;
            tag       <= col == 2'd3;
            out_last  <= 1'b0;
         end else if (out_valid) begin
            drain     <= drain + 2'd1;
            out_valid <= drain != 2'd3;
            out_last  <= tag && drain == 2'd2;
            sh        <= {sh[15:0], 8'h00};
            if (drain != 2'd3) out_byte <= sh[23:16];
         end
      end
   end
endmodule

// File: tb/tb_inv_mix_columns.sv
// tb_inv_mix_columns: directed-vector bench for inv_mix_columns
module tb_inv_mix_columns;
   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_byte = 8'h00;
   logic       bypass = 1'b0;
   logic       out_valid;
   logic [7:0] out_byte;
   logic       out_last;

   int nchk = 0;
   int nerr = 0;
   int cyc = 0;
   int tsent = 0;
   logic [7:0] ob[$];
   logic       ol[$];
   int         oc[$];

   inv_mix_columns dut (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_byte(in_byte),
      .bypass(bypass), .out_valid(out_valid), .out_byte(out_byte), .out_last(out_last)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   always @(negedge clock) if (reset_n && out_valid) begin
      ob.push_back(out_byte);
      ol.push_back(out_last);
      oc.push_back(cyc);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic clr();
      ob.delete();
      ol.delete();
      oc.delete();
   endtask

   task automatic send(input logic [7:0] b, input logic byp);
      @(negedge clock);
      in_valid = 1'b1;
      in_byte  = b;
      bypass   = byp;
      tsent    = cyc;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clock);
         in_valid = 1'b0;
      end
   endtask

   task automatic send_col(input logic [31:0] c, input logic byp, input logic gaps);
      for (int i = 0; i < 4; i++) begin
         send(c[31-8*i -: 8], byp);
         if (gaps) idle($urandom_range(0, 2));
      end
   endtask

   task automatic check_stream(input string tag, input int n, input logic [127:0] exp, input logic contig);
      chk({tag, " count"}, ob.size(), n);
      for (int i = 0; i < n && i < ob.size(); i++) begin
         chk($sformatf("%s byte%0d", tag, i), ob[i], exp[127-8*i -: 8]);
         if (contig) chk($sformatf("%s gap%0d", tag, i), oc[i] - oc[0], i);
      end
   endtask

   task automatic check_last(input string tag, input logic [15:0] exp);
      logic [15:0] m;
      m = 16'h0;
      foreach (ol[i]) m = {m[14:0], ol[i]};
      chk({tag, " last"}, m, exp);
   endtask

   task automatic check_clear(input string tag);
      #1;
      chk({tag, " valid"}, out_valid, 1'b0);
      chk({tag, " byte"}, out_byte, 8'h00);
      chk({tag, " last"}, out_last, 1'b0);
   endtask

   initial begin
      logic [31:0] rnd;
      repeat (3) @(negedge clock);
      check_clear("reset");
      @(negedge clock);
      reset_n = 1'b1;
      idle(2);

      clr();
      send_col(32'h8e4da1bc, 1'b0, 1'b0);
      idle(8);
      check_stream("col1", 4, {32'hdb135345, 96'h0}, 1'b1);
      if (oc.size() > 0) chk("col1 latency", oc[0], tsent + 1);

      clr();
      send_col(32'h9fdc589d, 1'b0, 1'b0);
      send_col(32'hd5d5d7d6, 1'b0, 1'b0);
      idle(8);
      check_stream("b2b", 8, {64'hf20a225cd4d4d4d5, 64'h0}, 1'b1);

      clr();
      send_col(32'h01010101, 1'b0, 1'b0);
      send_col(32'hc6c6c6c6, 1'b0, 1'b0);
      idle(8);
      check_stream("ident", 8, {64'h01010101c6c6c6c6, 64'h0}, 1'b1);

      clr();
      rnd = $urandom;
      send_col(rnd, 1'b1, 1'b0);
      idle(8);
      check_stream("bypass", 4, {rnd, 96'h0}, 1'b1);

      clr();
      send(8'h8e, 1'b0);
      send(8'h4d, 1'b1);
      send(8'ha1, 1'b1);
      send(8'hbc, 1'b1);
      send(8'h12, 1'b1);
      send(8'h34, 1'b0);
      send(8'h56, 1'b0);
      send(8'h78, 1'b0);
      idle(8);
      check_stream("toggle", 8, {64'hdb13534512345678, 64'h0}, 1'b1);

      clr();
      send_col(32'h8e4da1bc, 1'b0, 1'b1);
      send_col(32'h9fdc589d, 1'b0, 1'b1);
      send_col(32'hd5d5d7d6, 1'b0, 1'b1);
      send_col(32'h4d7ebdf8, 1'b0, 1'b1);
      idle(8);
      check_stream("block", 16, 128'hdb135345f20a225cd4d4d4d52d26314c, 1'b0);
      check_last("block", 16'h0001);

      clr();
      send_col(32'h8e4da1bc, 1'b0, 1'b0);
      idle(8);
      check_stream("wrap", 4, {32'hdb135345, 96'h0}, 1'b1);
      check_last("wrap", 16'h0000);

      send(8'h8e, 1'b0);
      send(8'h4d, 1'b0);
      idle(1);
      #2 reset_n = 1'b0;
      check_clear("rst col");
      @(negedge clock);
      reset_n = 1'b1;
      idle(1);
      clr();
      send_col(32'h8e4da1bc, 1'b0, 1'b0);
      send_col(32'h9fdc589d, 1'b0, 1'b0);
      send_col(32'hd5d5d7d6, 1'b0, 1'b0);
      send_col(32'h4d7ebdf8, 1'b0, 1'b0);
      idle(8);
      check_stream("after rst", 16, 128'hdb135345f20a225cd4d4d4d52d26314c, 1'b1);
      check_last("after rst", 16'h0001);

      send_col(32'h9fdc589d, 1'b0, 1'b0);
      idle(2);
      #2 reset_n = 1'b0;
      check_clear("rst drain");
      @(negedge clock);
      reset_n = 1'b1;
      idle(1);
      clr();
      send_col(32'hd5d5d7d6, 1'b0, 1'b0);
      idle(8);
      check_stream("drain rst", 4, {32'hd4d4d4d5, 96'h0}, 1'b1);
      check_last("drain rst", 16'h0000);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
